// File: rtl/query_weight_replay_buffer.sv
// Captures one weight matrix while forwarding it cut-through, then replays it
// REPEAT-1 more times so the upstream weight source is read once per matrix.
module query_weight_replay_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int DEPTH      = 32,
    parameter int REPEAT     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [LANES-1:0],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [LANES-1:0],
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last,
    output logic                  replaying
);

    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int CNT_W  = $clog2(REPEAT) + 1;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = LANES * DATA_WIDTH;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(REPEAT - 1);

    typedef enum logic {
        LOAD,
        REPLAY
    } state_t;

    state_t            state_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [CNT_W-1:0]  pass_cnt_reg;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] out_word;

    logic is_last;
    logic load_fire;
    logic replay_fire;

    // Lanes are flattened into one memory word so a block is a single entry.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign in_word[gi*DATA_WIDTH +: DATA_WIDTH] = data_in[gi];
            assign data_out[gi] = out_word[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign rd_word     = mem[ptr_reg[ADDR_W-1:0]];
    assign out_word    = (state_reg == REPLAY) ? rd_word : in_word;
    assign is_last     = (ptr_reg == LAST_PTR);
    assign load_fire   = !rst && (state_reg == LOAD) && data_in_valid && data_out_ready;
    assign replay_fire = !rst && (state_reg == REPLAY) && data_out_ready;

    always_comb begin
        data_out_valid = 1'b0;
        data_in_ready  = 1'b0;
        data_out_last  = 1'b0;
        replaying      = 1'b0;
        if (!rst) begin
            case (state_reg)
                LOAD: begin
                    data_out_valid = data_in_valid;
                    data_in_ready  = data_out_ready;
                    data_out_last  = data_in_valid && is_last;
                end
                REPLAY: begin
                    data_out_valid = 1'b1;
                    data_out_last  = is_last;
                    replaying      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Contents survive reset; the next load overwrites any partial matrix.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[ptr_reg[ADDR_W-1:0]] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= LOAD;
            ptr_reg      <= '0;
            pass_cnt_reg <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_fire) begin
                        if (is_last) begin
                            ptr_reg <= '0;
                            if (REPEAT > 1) begin
                                pass_cnt_reg <= CNT_W'(1);
                                state_reg    <= REPLAY;
                            end
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end
                REPLAY: begin
                    if (replay_fire) begin
                        if (is_last) begin
                            ptr_reg <= '0;
                            if (pass_cnt_reg == LAST_PASS) begin
                                pass_cnt_reg <= '0;
                                state_reg    <= LOAD;
                            end else begin
                                pass_cnt_reg <= pass_cnt_reg + 1'b1;
                            end
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_query_weight_replay_buffer.sv
// Directed bench for query_weight_replay_buffer across four configurations:
// D4/R3 with two lanes, D4/R1 pass-through, D4/R2 back-to-back, D1/R2.
module tb_query_weight_replay_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance a: DEPTH=4, REPEAT=3, LANES=2 (lane 1 carries value + 0x100)
    logic [15:0] a_din [1:0];
    logic [15:0] a_dout [1:0];
    logic a_div, a_dir, a_dov, a_dor, a_last, a_rep;
    // Instance b: DEPTH=4, REPEAT=1
    logic [15:0] b_din [0:0];
    logic [15:0] b_dout [0:0];
    logic b_div, b_dir, b_dov, b_dor, b_last, b_rep;
    // Instance c: DEPTH=4, REPEAT=2
    logic [15:0] c_din [0:0];
    logic [15:0] c_dout [0:0];
    logic c_div, c_dir, c_dov, c_dor, c_last, c_rep;
    // Instance d: DEPTH=1, REPEAT=2
    logic [15:0] d_din [0:0];
    logic [15:0] d_dout [0:0];
    logic d_div, d_dir, d_dov, d_dor, d_last, d_rep;

    query_weight_replay_buffer #(.DATA_WIDTH(16), .LANES(2), .DEPTH(4), .REPEAT(3)) dut_a (
        .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_div), .data_in_ready(a_dir),
        .data_out(a_dout), .data_out_valid(a_dov), .data_out_ready(a_dor),
        .data_out_last(a_last), .replaying(a_rep));
    query_weight_replay_buffer #(.DATA_WIDTH(16), .LANES(1), .DEPTH(4), .REPEAT(1)) dut_b (
        .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_div), .data_in_ready(b_dir),
        .data_out(b_dout), .data_out_valid(b_dov), .data_out_ready(b_dor),
        .data_out_last(b_last), .replaying(b_rep));
    query_weight_replay_buffer #(.DATA_WIDTH(16), .LANES(1), .DEPTH(4), .REPEAT(2)) dut_c (
        .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_div), .data_in_ready(c_dir),
        .data_out(c_dout), .data_out_valid(c_dov), .data_out_ready(c_dor),
        .data_out_last(c_last), .replaying(c_rep));
    query_weight_replay_buffer #(.DATA_WIDTH(16), .LANES(1), .DEPTH(1), .REPEAT(2)) dut_d (
        .clk(clk), .rst(rst), .data_in(d_din), .data_in_valid(d_div), .data_in_ready(d_dir),
        .data_out(d_dout), .data_out_valid(d_dov), .data_out_ready(d_dor),
        .data_out_last(d_last), .replaying(d_rep));

    task automatic a_drive(input logic valid, input logic [15:0] value, input logic ready);
        a_div    = valid;
        a_din[0] = value;
        a_din[1] = value + 16'h0100;
        a_dor    = ready;
    endtask

    task automatic idle_all();
        a_drive(1'b0, 16'h0000, 1'b1);
        b_div = 1'b0; b_din[0] = '0; b_dor = 1'b1;
        c_div = 1'b0; c_din[0] = '0; c_dor = 1'b1;
        d_div = 1'b0; d_din[0] = '0; d_dor = 1'b1;
    endtask

    // Shared expected-vector layout for instance a: {valid,last,in_ready,replaying,lane1,lane0}
    function automatic logic [35:0] a_exp(input logic v, input logic l, input logic ir,
                                          input logic rp, input logic [15:0] d);
        return {v, l, ir, rp, d + 16'h0100, d};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        a_drive(1'b1, 16'h0055, 1'b1);
        b_div = 1'b1; c_div = 1'b1; d_div = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({a_dov, a_dir, a_last, a_rep, b_dov, b_dir, b_last, b_rep,
             c_dov, c_dir, c_last, c_rep, d_dov, d_dir, d_last, d_rep} !== 16'h0000) begin
            $display("FAIL reset_outputs: got %b%b%b%b expected 0000 (inst a valid/ready/last/replaying)",
                     a_dov, a_dir, a_last, a_rep);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        idle_all();
        #1;
        n_total++;
        if ({a_dir, a_rep, a_dov} !== 3'b100) begin
            $display("FAIL reset_release_load: got ready/rep/valid=%b%b%b expected 100", a_dir, a_rep, a_dov);
        end else n_pass++;
    endtask

    task automatic test_pass_replay();
        logic [35:0] exp_v;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            a_drive(k < 4, 16'(k + 1), 1'b1);
            #1;
            exp_v = a_exp(1'b1, (k % 4) == 3, k < 4, k >= 4, 16'((k % 4) + 1));
            n_total++;
            if ({a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]} !== exp_v) begin
                $display("FAIL pass_replay beat %0d: got %h expected %h", k + 1,
                         {a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]}, exp_v);
            end else n_pass++;
        end
        @(negedge clk);
        a_drive(1'b0, 16'h0000, 1'b1);
        #1;
        n_total++;
        if ({a_rep, a_dir, a_dov} !== 3'b010) begin
            $display("FAIL pass_replay_return: got rep/ready/valid=%b%b%b expected 010", a_rep, a_dir, a_dov);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [35:0] exp_v;
        int blk;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_drive(1'b1, 16'(k + 1), 1'b1);
        end
        // Ready alternates 1,0,1,0...: each block is shown again on the stalled cycle.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            a_drive(1'b0, 16'h0000, (k % 2) == 0);
            #1;
            blk   = (k + 1) / 2;
            exp_v = a_exp(1'b1, (blk % 4) == 3, 1'b0, 1'b1, 16'((blk % 4) + 1));
            n_total++;
            if ({a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]} !== exp_v) begin
                $display("FAIL backpressure cycle %0d: got %h expected %h", k,
                         {a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]}, exp_v);
            end else n_pass++;
        end
        @(negedge clk);
        a_drive(1'b0, 16'h0000, 1'b1);
        #1;
        n_total++;
        if ({a_rep, a_dir} !== 2'b01) begin
            $display("FAIL backpressure_return: got rep/ready=%b%b expected 01", a_rep, a_dir);
        end else n_pass++;
    endtask

    task automatic test_valid_gaps();
        int vp [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [35:0] exp_v;
        logic [15:0] val;
        int n_acc = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            val = (vp[k] == 1) ? 16'(21 + n_acc) : 16'd99;
            a_drive(vp[k] == 1, val, 1'b1);
            #1;
            exp_v = a_exp(vp[k] == 1, (vp[k] == 1) && (n_acc == 3), 1'b1, 1'b0, val);
            n_total++;
            if ({a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]} !== exp_v) begin
                $display("FAIL valid_gaps cycle %0d: got %h expected %h", k,
                         {a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]}, exp_v);
            end else n_pass++;
            if (vp[k] == 1) n_acc++;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a_drive(1'b0, 16'd99, 1'b1);
            #1;
            exp_v = a_exp(1'b1, (k % 4) == 3, 1'b0, 1'b1, 16'(21 + (k % 4)));
            n_total++;
            if ({a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]} !== exp_v) begin
                $display("FAIL valid_gaps_replay beat %0d: got %h expected %h", k,
                         {a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]}, exp_v);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [35:0] exp_v;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_drive(k < 4, 16'(k + 1), 1'b1);
        end
        #1;
        n_total++;
        if ({a_rep, a_dout[0]} !== {1'b1, 16'd1}) begin
            $display("FAIL midreset_beat5: got rep=%b data=%0d expected rep=1 data=1", a_rep, a_dout[0]);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        a_drive(1'b1, 16'd77, 1'b1);
        #1;
        n_total++;
        if ({a_dov, a_dir, a_last, a_rep} !== 4'b0000) begin
            $display("FAIL midreset_outputs: got %b%b%b%b expected 0000", a_dov, a_dir, a_last, a_rep);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            a_drive(k < 4, 16'(9 + (k % 4)), 1'b1);
            #1;
            exp_v = a_exp(1'b1, (k % 4) == 3, k < 4, k >= 4, 16'(9 + (k % 4)));
            n_total++;
            if ({a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]} !== exp_v) begin
                $display("FAIL midreset_reload beat %0d: got %h expected %h", k + 1,
                         {a_dov, a_last, a_dir, a_rep, a_dout[1], a_dout[0]}, exp_v);
            end else n_pass++;
        end
        @(negedge clk);
        a_drive(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_pass_through();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b_div = 1'b1; b_din[0] = 16'(31 + k); b_dor = 1'b1;
            #1;
            n_total++;
            if ({b_dov, b_last, b_dir, b_rep, b_dout[0]} !== {1'b1, (k % 4) == 3, 1'b1, 1'b0, 16'(31 + k)}) begin
                $display("FAIL pass_through block %0d: got v=%b l=%b r=%b rep=%b d=%0d expected d=%0d last=%b",
                         k + 1, b_dov, b_last, b_dir, b_rep, b_dout[0], 31 + k, (k % 4) == 3);
            end else n_pass++;
        end
        @(negedge clk);
        b_div = 1'b0;
    endtask

    task automatic test_back_to_back();
        int si = 0;
        int exp_d;
        logic exp_ir;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            c_div = (si < 8); c_din[0] = (si < 8) ? 16'(si + 1) : 16'd0; c_dor = 1'b1;
            #1;
            exp_d  = (k < 4) ? k + 1 : (k < 12) ? k - 3 : k - 7;
            exp_ir = (k < 4) || (k >= 8 && k < 12);
            n_total++;
            if ({c_dov, c_last, c_dir, c_rep, c_dout[0]} !== {1'b1, (k % 4) == 3, exp_ir, !exp_ir, 16'(exp_d)}) begin
                $display("FAIL back_to_back cycle %0d: got v=%b l=%b r=%b rep=%b d=%0d expected l=%b r=%b d=%0d",
                         k, c_dov, c_last, c_dir, c_rep, c_dout[0], (k % 4) == 3, exp_ir, exp_d);
            end else n_pass++;
            if (c_div && c_dir) si++;
        end
        @(negedge clk);
        c_div = 1'b0;
    endtask

    task automatic test_depth_one();
        int si = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d_div = (si < 2); d_din[0] = 16'(50 + si); d_dor = 1'b1;
            #1;
            n_total++;
            if ({d_dov, d_last, d_dir, d_rep, d_dout[0]} !== {1'b1, 1'b1, (k % 2) == 0, (k % 2) == 1, 16'(50 + k / 2)}) begin
                $display("FAIL depth_one cycle %0d: got v=%b l=%b r=%b rep=%b d=%0d expected d=%0d",
                         k, d_dov, d_last, d_dir, d_rep, d_dout[0], 50 + k / 2);
            end else n_pass++;
            if (d_div && d_dir) si++;
        end
        @(negedge clk);
        d_div = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_replay();
        test_backpressure();
        test_valid_gaps();
        test_reset_mid_pass();
        test_pass_through();
        test_back_to_back();
        test_depth_one();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/query_weight_replay_buffer.md
Name: query_weight_replay_buffer

Overview:
- Sits directly downstream of the query weight source, between the weight ROM stream and the query linear layer.
- On the first pass it forwards one full weight matrix, DEPTH blocks of LANES elements each, straight through to the consumer and captures it into an internal register array.
- It then replays the captured matrix REPEAT-1 more times, once per sequence tile the linear layer processes.
- It supplies a proper valid/ready stream, so the upstream source is only read once per matrix.

Parameters:
- DATA_WIDTH, 16, bits per weight element.
- LANES, 1, elements per block (PARALLELISM_DIM_0 * PARALLELISM_DIM_1).
- DEPTH, 32, blocks per matrix pass; must be >= 1.
- REPEAT, 4, total passes per loaded matrix, including the first; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- data_in  input  DATA_WIDTH x LANES (unpacked array [LANES-1:0])  weight block from source.
- data_in_valid  input  1  upstream block valid.
- data_in_ready  output  1  block accepted when valid&ready.
- data_out  output  DATA_WIDTH x LANES (unpacked array [LANES-1:0])  weight block to consumer.
- data_out_valid  output  1  downstream block valid.
- data_out_ready  input  1  consumer ready.
- data_out_last  output  1  marks final block of each pass.
- replaying  output  1  high while in REPLAY state.

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - While rst is high: data_out_valid=0, data_in_ready=0, data_out_last=0, replaying=0.
  - On release: state=LOAD, ptr=0, pass_cnt=0.
  - Memory contents are not cleared.
- Counters:
  - ptr is $clog2(DEPTH)+1 bits, wraps DEPTH-1 -> 0.
  - pass_cnt is $clog2(REPEAT)+1 bits.
  - mem is DEPTH entries of LANES*DATA_WIDTH bits, written synchronously and read combinationally (distributed RAM).
- LOAD state (cut-through, zero latency):
  - data_out = data_in; data_out_valid = data_in_valid; data_in_ready = data_out_ready.
  - On handshake: mem[ptr] <= data_in, ptr++.
  - data_out_last = data_in_valid & (ptr==DEPTH-1).
  - On the handshake with ptr==DEPTH-1: ptr<=0.
    - If REPEAT==1: stay in LOAD.
    - Else: pass_cnt<=1, go to REPLAY.
- REPLAY state:
  - data_in_ready=0; data_out = mem[ptr]; data_out_valid=1; replaying=1.
  - data_out_last = (ptr==DEPTH-1).
  - On downstream handshake: ptr++.
  - At ptr==DEPTH-1 handshake: ptr<=0, pass_cnt++.
    - If pass_cnt==REPEAT-1: pass_cnt<=0, go to LOAD.
- Timing: the first REPLAY beat is valid the cycle after the final LOAD handshake. The first LOAD beat of the next matrix can be accepted the cycle after the final REPLAY handshake. There are no bubbles beyond those imposed by the handshakes.
- Backpressure: while valid & !ready, data_out and data_out_last hold stable. In LOAD this is the upstream's obligation, since data_in_ready is low.
- No skipped or duplicated blocks under any ready pattern.
- rst mid-pass: abandons the pass and returns to LOAD at ptr 0. Partial memory contents are overwritten by the next load.
- DEPTH==1: every beat is last; each pass is a single handshake.

Test Plan:
1. DEPTH=4, REPEAT=3, data_in=1,2,3,4 back-to-back, data_out_ready=1 -> data_out 1,2,3,4,1,2,3,4,1,2,3,4 on 12 consecutive cycles. data_out_last on beats 4,8,12. data_in_ready low for cycles 5-12. replaying high for cycles 5-12.
2. Same config, data_out_ready pattern 1,0,1,0 during replay -> each block held while ready=0. Sequence 1,2,3,4 per pass exactly, no skip or duplicate.
3. LOAD with data_in_valid gaps (valid 1,0,0,1,1,0,1) -> data_out_valid mirrors data_in_valid. Only 4 writes occur. Replay returns blocks in acceptance order.
4. REPEAT=1, DEPTH=4, stream 8 blocks -> pure pass-through. replaying never asserts. data_out_last on blocks 4 and 8.
5. rst asserted for 1 cycle after the 5th output beat of test 1 -> outputs 0 during rst, then LOAD at ptr 0. Load 9,10,11,12 -> replay yields 9,10,11,12 twice.
6. Two matrices back-to-back (A=1..4, B=5..8, REPEAT=2) -> output 1,2,3,4,1,2,3,4,5,6,7,8,5,6,7,8. B's first beat is accepted the cycle after A's final replay handshake.
